// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch constants, state encoding and PC helpers
package instr_fetch_pkg;

    localparam int          ROM_ADDRESS_BITWIDTH = 8;
    localparam logic [31:0] ROM_SIZE             = 32'd256;
    localparam logic [31:0] PC_INC               = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT,
        S_FAULT
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM port, decode handshake and control signals of the fetch unit
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address;
    logic [31:0]                     rom_data;
    logic [31:0]                     inst;
    logic [31:0]                     inst_pc;
    logic                            inst_valid;
    logic                            inst_ready;
    logic                            redirect_valid;
    logic [31:0]                     redirect_pc;
    logic                            halt_req;
    logic                            halted;
    logic                            fetch_fault;
    logic [31:0]                     fetch_count;

    modport master (
        output rom_address, inst, inst_pc, inst_valid, halted, fetch_fault, fetch_count,
        input  rom_data, inst_ready, redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  rom_address, inst, inst_pc, inst_valid, halted, fetch_fault, fetch_count,
        output rom_data, inst_ready, redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit driving a registered ROM and a valid/ready decode port
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_fetch_if.master  fif
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_count;

    logic         w_oob;
    logic         w_valid;
    logic         w_transfer;
    logic [31:0]  w_target;
    logic [31:0]  w_next_pc;

    always_comb begin
        w_target   = word_align(fif.redirect_pc);
        w_oob      = (r_pc >= ROM_SIZE);
        w_valid    = reset_n && (r_state == S_RUN) && !fif.redirect_valid && !w_oob;
        w_transfer = w_valid && fif.inst_ready;
        // The ROM is addressed with the PC we will hold next cycle, so its
        // registered output always lines up with r_pc while running.
        w_next_pc  = r_pc;
        if (!reset_n) begin
            w_next_pc = RESET_PC;
        end else begin
            case (r_state)
                S_BOOT:  w_next_pc = fif.redirect_valid ? w_target : RESET_PC;
                S_RUN: begin
                    if (fif.redirect_valid)
                        w_next_pc = w_target;
                    else if (w_transfer && !fif.halt_req)
                        w_next_pc = r_pc + PC_INC;
                end
                default: if (fif.redirect_valid) w_next_pc = w_target;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_pc <= w_next_pc;
        if (!reset_n) begin
            r_state <= S_BOOT;
            r_count <= 32'd0;
        end else begin
            if (w_transfer)
                r_count <= r_count + 32'd1;
            case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (fif.redirect_valid)
                        r_state <= S_RUN;
                    else if (w_oob)
                        r_state <= S_FAULT;
                    else if (w_transfer && fif.halt_req)
                        r_state <= S_HALT;
                end
                default: if (fif.redirect_valid) r_state <= S_RUN;
            endcase
        end
    end

    assign fif.rom_address = w_next_pc[ROM_ADDRESS_BITWIDTH-1:0];
    assign fif.inst        = fif.rom_data;
    assign fif.inst_pc     = r_pc;
    assign fif.inst_valid  = w_valid;
    assign fif.halted      = reset_n && (r_state == S_HALT);
    assign fif.fetch_fault = reset_n && (r_state == S_FAULT);
    assign fif.fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized check of instr_fetch against a behavioural model
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int MODE_BOOT = 0, MODE_RUN = 1, MODE_HALT = 2, MODE_FAULT = 3;
    localparam int ROM_WORDS = ROM_SIZE / 4;

    logic clk;
    logic reset_n;
    logic [31:0] rom_mem [ROM_WORDS];
    logic [31:0] rom_q;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_known = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fif     (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_mem[bus.rom_address[ROM_ADDRESS_BITWIDTH-1:2]];
    assign bus.rom_data = rom_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the fetcher has done so far, advanced once per edge.
    always @(posedge clk) begin
        logic [31:0] tgt;
        tgt = {bus.redirect_pc[31:2], 2'b00};
        if (!reset_n) begin
            m_mode = MODE_BOOT; m_pc = RST_PC; m_cnt = 0; m_known = 1;
        end else if (m_known) begin
            if (m_mode == MODE_BOOT) begin
                m_mode = MODE_RUN;
                m_pc   = bus.redirect_valid ? tgt : RST_PC;
            end else if (m_mode == MODE_RUN) begin
                if (bus.redirect_valid) m_pc = tgt;
                else if (m_pc >= ROM_SIZE) m_mode = MODE_FAULT;
                else if (bus.inst_ready) begin
                    m_cnt = m_cnt + 1;
                    if (bus.halt_req) m_mode = MODE_HALT;
                    else m_pc = m_pc + 4;
                end
            end else if (bus.redirect_valid) begin
                m_mode = MODE_RUN; m_pc = tgt;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_valid, e_halt, e_fault;
        logic [31:0] e_addr;
        if (m_known) begin
            e_valid = 0; e_halt = 0; e_fault = 0; e_addr = m_pc;
            if (!reset_n) e_addr = RST_PC;
            else if (bus.redirect_valid) e_addr = {bus.redirect_pc[31:2], 2'b00};
            else if (m_mode == MODE_BOOT) e_addr = RST_PC;
            else if (m_mode == MODE_RUN && m_pc < ROM_SIZE) begin
                e_valid = 1;
                if (bus.inst_ready && !bus.halt_req) e_addr = m_pc + 4;
            end
            if (reset_n) begin
                e_halt  = (m_mode == MODE_HALT);
                e_fault = (m_mode == MODE_FAULT);
            end
            chk("rom_address", 32'(bus.rom_address), 32'(e_addr[ROM_ADDRESS_BITWIDTH-1:0]));
            chk("inst_valid", 32'(bus.inst_valid), 32'(e_valid));
            chk("halted", 32'(bus.halted), 32'(e_halt));
            chk("fetch_fault", 32'(bus.fetch_fault), 32'(e_fault));
            chk("fetch_count", bus.fetch_count, m_cnt);
            if (e_valid) begin
                chk("inst_pc", bus.inst_pc, m_pc);
                chk("inst", bus.inst, rom_mem[m_pc[ROM_ADDRESS_BITWIDTH-1:2]]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string name, input logic [31:0] pc, input logic [31:0] cnt);
        #1;
        chk({name, ".valid"}, 32'(bus.inst_valid), 32'd1);
        chk({name, ".pc"}, bus.inst_pc, pc);
        chk({name, ".inst"}, bus.inst, 32'hA5A5_0000 + (pc >> 2));
        chk({name, ".count"}, bus.fetch_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = 32'hA5A5_0000 + 32'(i);
        reset_n = 0; bus.inst_ready = 1; bus.redirect_valid = 0;
        bus.redirect_pc = 0; bus.halt_req = 0;
        repeat (3) tick();
        reset_n = 1;
        #1;
        chk("boot.valid", 32'(bus.inst_valid), 32'd0);
        chk("boot.rom_address", 32'(bus.rom_address), 32'd0);
        chk("boot.count", bus.fetch_count, 32'd0);

        for (int i = 0; i < 4; i++) begin
            tick();
            show("seq", 32'(i * 4), 32'(i));
        end
        tick();
        show("seq_end", 32'd16, 32'd4);

        bus.redirect_valid = 1; bus.redirect_pc = 32'd4;
        #1 chk("redir.valid", 32'(bus.inst_valid), 32'd0);
        tick();
        bus.redirect_valid = 0; bus.inst_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            show("stall", 32'd4, 32'd4);
        end
        bus.inst_ready = 1;
        tick();
        show("after_stall", 32'd8, 32'd5);

        bus.redirect_valid = 1; bus.redirect_pc = 32'h0000_0013;
        #1 chk("redir13.valid", 32'(bus.inst_valid), 32'd0);
        tick();
        bus.redirect_valid = 0;
        show("redir13", 32'h10, 32'd5);

        bus.redirect_valid = 1; bus.redirect_pc = 32'd4;
        tick();
        bus.redirect_valid = 0; bus.halt_req = 1;
        show("halt_src", 32'd4, 32'd5);
        tick();
        bus.halt_req = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            chk("halt.halted", 32'(bus.halted), 32'd1);
            chk("halt.valid", 32'(bus.inst_valid), 32'd0);
            chk("halt.count", bus.fetch_count, 32'd6);
        end
        bus.redirect_valid = 1; bus.redirect_pc = 32'd0;
        tick();
        bus.redirect_valid = 0;
        #1 chk("unhalt.halted", 32'(bus.halted), 32'd0);
        show("unhalt", 32'd0, 32'd6);

        bus.redirect_valid = 1; bus.redirect_pc = ROM_SIZE - 4;
        tick();
        bus.redirect_valid = 0;
        show("last", ROM_SIZE - 4, 32'd6);
        tick();
        #1;
        chk("oob.valid", 32'(bus.inst_valid), 32'd0);
        chk("oob.count", bus.fetch_count, 32'd7);
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            chk("fault.flag", 32'(bus.fetch_fault), 32'd1);
            chk("fault.valid", 32'(bus.inst_valid), 32'd0);
        end
        bus.redirect_valid = 1; bus.redirect_pc = 32'd0;
        tick();
        bus.redirect_valid = 0;
        #1 chk("unfault.flag", 32'(bus.fetch_fault), 32'd0);
        show("unfault", 32'd0, 32'd7);

        bus.redirect_valid = 1; bus.redirect_pc = 32'h40; reset_n = 0;
        tick();
        #1;
        chk("rst.valid", 32'(bus.inst_valid), 32'd0);
        chk("rst.rom_address", 32'(bus.rom_address), 32'd0);
        chk("rst.count", bus.fetch_count, 32'd0);
        bus.redirect_valid = 0; reset_n = 1;
        #1;
        chk("rst_boot.valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_boot.halted", 32'(bus.halted), 32'd0);
        tick();
        show("rst_run", 32'd0, 32'd0);

        reset_n = 0;
        tick();
        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
        tick();
        reset_n = 1;
        for (int c = 0; c < 4000; c++) begin
            reset_n            = ($urandom_range(0, 199) != 0);
            bus.inst_ready     = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc    = $urandom_range(0, 287);
            bus.halt_req       = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
